// File: rtl/serial_pattern_pkg.sv
// Shared types and helpers for the serial pattern transmitter.
package serial_pattern_pkg;

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

   function automatic int len_w(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/serial_pattern_shifter.sv
// Pattern shift register with a saved copy for back-to-back repeats.
module serial_pattern_shifter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         reload,
   input  logic         shift,
   input  logic [W-1:0] din,
   output logic         msb
);

   logic [W-1:0] sr;
   logic [W-1:0] saved;

   always_ff @(posedge clk) begin
      if (rst) begin
         sr    <= '0;
         saved <= '0;
      end else if (load) begin
         sr    <= din;
         saved <= din;
      end else if (reload) begin
         sr <= saved;
      end else if (shift) begin
         sr <= sr << 1;
      end
   end

   assign msb = sr[W-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial bit-pattern transmitter: MSB-first, optional repeats, done pulse.
module serial_pattern_tx
   import serial_pattern_pkg::*;
#(
   parameter int W     = 8,
   parameter int RPT_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [W-1:0]         req_pattern,
   input  logic [len_w(W)-1:0]  req_len,
   input  logic [RPT_W-1:0]     req_repeat,
   output logic                 bit_out,
   output logic                 bit_valid,
   output logic                 done
);

   localparam int LW = len_w(W);

   state_t           state_q, state_d;
   logic [LW-1:0]    bit_cnt, len_q, eff_len;
   logic [RPT_W-1:0] rpt_cnt;
   logic [W-1:0]     aligned;
   logic             msb, load, reload, shift, last_bit;

   // Left-align so the first bit always leaves from the MSB.
   assign eff_len  = (req_len > LW'(W)) ? LW'(W) : req_len;
   assign aligned  = req_pattern << (LW'(W) - eff_len);
   assign last_bit = (bit_cnt == LW'(1));

   serial_pattern_shifter #(.W(W)) u_shifter (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .reload (reload),
      .shift  (shift),
      .din    (aligned),
      .msb    (msb)
   );

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      bit_valid = 1'b0;
      bit_out   = 1'b0;
      done      = 1'b0;
      load      = 1'b0;
      reload    = 1'b0;
      shift     = 1'b0;
      unique case (state_q)
         IDLE: begin
            req_ready = ~rst;
            if (req_valid && !rst) begin
               load    = 1'b1;
               state_d = (eff_len == '0) ? DONE : SEND;
            end
         end
         SEND: begin
            bit_valid = 1'b1;
            bit_out   = msb;
            if (last_bit && rpt_cnt != '0) begin
               reload = 1'b1;
            end else begin
               shift = 1'b1;
               if (last_bit) state_d = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         bit_cnt <= '0;
         len_q   <= '0;
         rpt_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            bit_cnt <= eff_len;
            len_q   <= eff_len;
            rpt_cnt <= req_repeat;
         end else if (reload) begin
            bit_cnt <= len_q;
            rpt_cnt <= rpt_cnt - RPT_W'(1);
         end else if (shift) begin
            bit_cnt <= bit_cnt - LW'(1);
         end
      end
   end

endmodule
